// File: rtl/uart_pkg.sv
// Shared types and counter widths for the UART transmit datapath.
package uart_pkg;

   localparam int unsigned LatCntW = 3;
   localparam int unsigned GapCntW = 8;

   typedef enum logic [2:0] {
      StIdle,
      StPop,
      StWaitData,
      StLoad,
      StWaitAck,
      StWaitDone,
      StGap,
      StFlush
   } tx_seq_state_t;

endpackage

// File: rtl/uart_tx_fifo_sequencer_if.sv
// FIFO-side and transmitter-side signals of the TX FIFO sequencer.
interface uart_tx_fifo_sequencer_if #(
   parameter int unsigned CNT_BITS = 16
) ();

   logic                tx_enable;
   logic                flush;
   logic                fifo_empty;
   logic [7:0]          fifo_do;
   logic                fifo_rd_n;
   logic                tx_busy;
   logic                tx_load;
   logic [7:0]          tx_data;
   logic                idle;
   logic                flush_done;
   logic [CNT_BITS-1:0] bytes_sent;

   modport master (
      input  tx_enable, flush, fifo_empty, fifo_do, tx_busy,
      output fifo_rd_n, tx_load, tx_data, idle, flush_done, bytes_sent
   );

   modport slave (
      output tx_enable, flush, fifo_empty, fifo_do, tx_busy,
      input  fifo_rd_n, tx_load, tx_data, idle, flush_done, bytes_sent
   );

endinterface

// File: rtl/uart_tx_fifo_sequencer.sv
// Moves bytes from the TX FIFO into the shift register one at a time; also drains the FIFO on flush.
module uart_tx_fifo_sequencer
   import uart_pkg::*;
#(
   parameter int unsigned RD_LATENCY = 2,
   parameter int unsigned GAP_CYCLES = 0,
   parameter int unsigned CNT_BITS   = 16
) (
   input logic                        clock,
   input logic                        reset_n,
   uart_tx_fifo_sequencer_if.master   bus
);

   localparam logic [LatCntW-1:0] LatInit = LatCntW'(RD_LATENCY - 1);
   localparam logic [GapCntW-1:0] GapInit = GapCntW'(GAP_CYCLES - 1);
   localparam logic               HasGap  = (GAP_CYCLES != 0);

   tx_seq_state_t       state_q, state_d;
   logic                rd_n_q, rd_n_d;
   logic                tx_load_q, tx_load_d;
   logic [7:0]          tx_data_q, tx_data_d;
   logic                idle_q, idle_d;
   logic                flush_done_q, flush_done_d;
   logic [CNT_BITS-1:0] bytes_q, bytes_d;
   logic [LatCntW-1:0]  lat_q, lat_d;
   logic [GapCntW-1:0]  gap_q, gap_d;

   always_comb begin
      state_d      = state_q;
      rd_n_d       = 1'b1;
      tx_load_d    = 1'b0;
      tx_data_d    = tx_data_q;
      flush_done_d = 1'b0;
      bytes_d      = bytes_q;
      lat_d        = lat_q;
      gap_d        = gap_q;
      unique case (state_q)
         StIdle: begin
            if (bus.flush) begin
               state_d = StFlush;
            end else if (bus.tx_enable && !bus.fifo_empty && !bus.tx_busy) begin
               state_d = StPop;
               rd_n_d  = 1'b0;
            end
         end
         StPop: begin
            state_d = StWaitData;
            lat_d   = LatInit;
         end
         StWaitData: begin
            // Load strobe and count are registered together with the captured byte.
            if (lat_q == '0) begin
               tx_data_d = bus.fifo_do;
               tx_load_d = 1'b1;
               bytes_d   = bytes_q + CNT_BITS'(1);
               state_d   = StLoad;
            end else begin
               lat_d = lat_q - LatCntW'(1);
            end
         end
         StLoad: state_d = StWaitAck;
         StWaitAck: begin
            if (bus.tx_busy) state_d = StWaitDone;
         end
         StWaitDone: begin
            if (!bus.tx_busy) begin
               if (HasGap) begin
                  state_d = StGap;
                  gap_d   = GapInit;
               end else begin
                  state_d = StIdle;
               end
            end
         end
         StGap: begin
            if (gap_q == '0) state_d = StIdle;
            else             gap_d   = gap_q - GapCntW'(1);
         end
         StFlush: begin
            // Every read is followed by a high cycle so the empty flag is never stale.
            if (rd_n_q) begin
               if (!bus.fifo_empty) begin
                  rd_n_d = 1'b0;
               end else begin
                  flush_done_d = 1'b1;
                  state_d      = StIdle;
               end
            end
         end
         default: state_d = StIdle;
      endcase
      idle_d = (state_d == StIdle);
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q      <= StIdle;
         rd_n_q       <= 1'b1;
         tx_load_q    <= 1'b0;
         tx_data_q    <= 8'h00;
         idle_q       <= 1'b1;
         flush_done_q <= 1'b0;
         bytes_q      <= '0;
         lat_q        <= '0;
         gap_q        <= '0;
      end else begin
         state_q      <= state_d;
         rd_n_q       <= rd_n_d;
         tx_load_q    <= tx_load_d;
         tx_data_q    <= tx_data_d;
         idle_q       <= idle_d;
         flush_done_q <= flush_done_d;
         bytes_q      <= bytes_d;
         lat_q        <= lat_d;
         gap_q        <= gap_d;
      end
   end

   assign bus.fifo_rd_n  = rd_n_q;
   assign bus.tx_load    = tx_load_q;
   assign bus.tx_data    = tx_data_q;
   assign bus.idle       = idle_q;
   assign bus.flush_done = flush_done_q;
   assign bus.bytes_sent = bytes_q;

endmodule

// File: tb/tb_uart_tx_fifo_sequencer.sv
// Directed bench: FIFO and transmitter models around the sequencer, with a byte scoreboard.
module tb_uart_tx_fifo_sequencer;

   localparam int RdLat      = 2;
   localparam int Gap        = 4;
   localparam int BusyCycles = 10;

   logic clock;
   logic reset_n;

   uart_tx_fifo_sequencer_if #(.CNT_BITS(16)) sif ();

   uart_tx_fifo_sequencer #(
      .RD_LATENCY(RdLat),
      .GAP_CYCLES(Gap),
      .CNT_BITS  (16)
   ) dut (
      .clock  (clock),
      .reset_n(reset_n),
      .bus    (sif)
   );

   initial begin
      clock = 1'b0;
      forever #5 clock = ~clock;
   end

   int n_cmp = 0;
   int n_err = 0;

   // FIFO contents: written by the stimulus, popped by the model
   logic [7:0] fmem [64];
   int wr_ptr = 0;
   int rd_ptr = 0;
   assign sif.fifo_empty = (wr_ptr == rd_ptr);

   logic [7:0] pipe_d [8];
   bit         pipe_v [8];
   int cyc = 0, rd_cnt = 0, load_cnt = 0, fd_cnt = 0, n_fall = 0;
   int busy_rem = 0, underflow_cnt = 0, adj_cnt = 0;
   bit prev_rd_low = 0;
   bit rd_low;
   int pop_cyc [64];
   int load_cyc [64];
   int fall_cyc [64];
   logic [7:0] got [64];
   logic [7:0] sb [$];

   // Read data is only valid for the single cycle around the capture edge.
   always @(negedge clock) begin
      cyc++;
      rd_low = (sif.fifo_rd_n === 1'b0);
      if (rd_low && prev_rd_low) adj_cnt++;
      prev_rd_low = rd_low;
      for (int i = 7; i > 0; i--) begin
         pipe_d[i] = pipe_d[i-1];
         pipe_v[i] = pipe_v[i-1];
      end
      pipe_v[0] = 1'b0;
      pipe_d[0] = 8'hEE;
      if (rd_low) begin
         pop_cyc[rd_cnt % 64] = cyc;
         rd_cnt++;
         if (wr_ptr == rd_ptr) begin
            underflow_cnt++;
         end else begin
            pipe_v[0] = 1'b1;
            pipe_d[0] = fmem[rd_ptr % 64];
            rd_ptr++;
         end
      end
      sif.fifo_do = pipe_v[RdLat] ? pipe_d[RdLat] : 8'hEE;
      if (busy_rem > 0) begin
         busy_rem--;
         if (busy_rem == 0) begin
            fall_cyc[n_fall % 64] = cyc;
            n_fall++;
         end
      end
      if (sif.tx_load === 1'b1) begin
         got[load_cnt % 64]      = sif.tx_data;
         load_cyc[load_cnt % 64] = cyc;
         load_cnt++;
         busy_rem = BusyCycles;
      end
      sif.tx_busy = (busy_rem != 0);
      if (sif.flush_done === 1'b1) fd_cnt++;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic push_byte(input logic [7:0] b, input bit expect_tx);
      fmem[wr_ptr % 64] = b;
      wr_ptr++;
      if (expect_tx) sb.push_back(b);
   endtask

   task automatic wait_loads(input int n);
      int budget = 0;
      while (load_cnt < n && budget < 300) begin
         @(negedge clock);
         budget++;
      end
      check("load_wait", 32'(load_cnt >= n), 1);
   endtask

   task automatic wait_idle();
      int budget = 0;
      while (sif.idle !== 1'b1 && budget < 300) begin
         @(negedge clock);
         budget++;
      end
      check("idle_wait", 32'(sif.idle), 1);
   endtask

   task automatic check_load(input int idx, input string tag);
      logic [7:0] exp;
      exp = (sb.size() > 0) ? sb.pop_front() : 8'hxx;
      check(tag, 32'(got[idx % 64]), 32'(exp));
   endtask

   int rd_before, ld_before, fd_before, bs_before, budget;

   initial begin
      reset_n       = 1'b0;
      sif.tx_enable = 1'b0;
      sif.flush     = 1'b0;
      repeat (3) @(negedge clock);
      check("rst_rd_n", 32'(sif.fifo_rd_n), 1);
      check("rst_tx_load", 32'(sif.tx_load), 0);
      check("rst_tx_data", 32'(sif.tx_data), 0);
      check("rst_idle", 32'(sif.idle), 1);
      check("rst_flush_done", 32'(sif.flush_done), 0);
      check("rst_bytes_sent", 32'(sif.bytes_sent), 0);
      reset_n = 1'b1;
      repeat (2) @(negedge clock);

      // Single byte: one read strobe, load 1+RD_LATENCY cycles later.
      push_byte(8'hA5, 1);
      sif.tx_enable = 1'b1;
      wait_loads(1);
      wait_idle();
      check("single_rd_cnt", 32'(rd_cnt), 1);
      check("single_load_delay", 32'(load_cyc[0] - pop_cyc[0]), 32'(1 + RdLat));
      check_load(0, "single_data");
      check("single_bytes_sent", 32'(sif.bytes_sent), 1);

      // Three bytes back to back with the inter-byte gap.
      push_byte(8'h01, 1);
      push_byte(8'h02, 1);
      push_byte(8'h03, 1);
      wait_loads(4);
      wait_idle();
      check_load(1, "burst_data0");
      check_load(2, "burst_data1");
      check_load(3, "burst_data2");
      check("burst_gap1", 32'(pop_cyc[2] - fall_cyc[1]), 32'(Gap + 2));
      check("burst_gap2", 32'(pop_cyc[3] - fall_cyc[2]), 32'(Gap + 2));
      check("burst_bytes_sent", 32'(sif.bytes_sent), 4);

      // Enable dropped mid-byte: that byte finishes, the rest stay queued.
      push_byte(8'h10, 1);
      push_byte(8'h11, 0);
      push_byte(8'h12, 0);
      wait_loads(5);
      repeat (4) @(negedge clock);
      sif.tx_enable = 1'b0;
      rd_before = rd_cnt;
      wait_idle();
      repeat (30) @(negedge clock);
      check_load(4, "disable_data");
      check("disable_no_read", 32'(rd_cnt), 32'(rd_before));
      check("disable_idle", 32'(sif.idle), 1);
      check("disable_bytes_sent", 32'(sif.bytes_sent), 5);
      check("disable_fifo_left", 32'(wr_ptr - rd_ptr), 2);

      // Flush with five bytes queued.
      push_byte(8'h13, 0);
      push_byte(8'h14, 0);
      push_byte(8'h15, 0);
      rd_before = rd_cnt;
      ld_before = load_cnt;
      fd_before = fd_cnt;
      bs_before = int'(sif.bytes_sent);
      sif.flush = 1'b1;
      budget    = 0;
      while (sif.flush_done !== 1'b1 && budget < 100) begin
         @(negedge clock);
         budget++;
      end
      sif.flush = 1'b0;
      check("flush_done_seen", 32'(sif.flush_done), 1);
      repeat (5) @(negedge clock);
      check("flush_reads", 32'(rd_cnt - rd_before), 5);
      check("flush_no_load", 32'(load_cnt), 32'(ld_before));
      check("flush_done_pulses", 32'(fd_cnt - fd_before), 1);
      check("flush_bytes_sent", 32'(sif.bytes_sent), 32'(bs_before));
      check("flush_empty", 32'(sif.fifo_empty), 1);
      check("flush_idle", 32'(sif.idle), 1);

      // Asynchronous reset while waiting on read data.
      push_byte(8'h77, 0);
      sif.tx_enable = 1'b1;
      budget        = 0;
      while (sif.fifo_rd_n !== 1'b0 && budget < 50) begin
         @(negedge clock);
         budget++;
      end
      check("arst_pop_seen", 32'(sif.fifo_rd_n), 0);
      @(negedge clock);
      reset_n = 1'b0;
      #1;
      check("arst_rd_n", 32'(sif.fifo_rd_n), 1);
      check("arst_tx_load", 32'(sif.tx_load), 0);
      check("arst_tx_data", 32'(sif.tx_data), 0);
      check("arst_idle", 32'(sif.idle), 1);
      check("arst_bytes_sent", 32'(sif.bytes_sent), 0);
      @(negedge clock);
      reset_n   = 1'b1;
      ld_before = load_cnt;
      rd_before = rd_cnt;
      repeat (15) @(negedge clock);
      check("arst_no_load", 32'(load_cnt), 32'(ld_before));
      check("arst_no_read", 32'(rd_cnt), 32'(rd_before));

      check("no_underflow", 32'(underflow_cnt), 0);
      check("no_adjacent_reads", 32'(adj_cnt), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
